jpeg_byte_packer: RTL

- Sits directly downstream of jpeg_top and consumes its 32-bit JPEG_bitstream words.
- Buffers the words in a small FIFO and serializes them MSB-first into a byte stream with a valid/ready handshake.
- Closes the final partial word: pads it with 1s to a byte boundary, byte-stuffs a padded 0xFF, then appends the EOI marker (FF D9).
- Full words arrive from jpeg_top already byte-stuffed; this block stuffs only the padded final byte.

---
 rtl/jpeg_byte_packer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jpeg_byte_packer.sv
// Byte packer for jpeg_top: buffers 32-bit bitstream words and emits them MSB-first as bytes.
// Closes the final partial word with 1-padding, stuffs a padded 0xFF, and optionally appends FF D9.
module jpeg_byte_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter bit APPEND_EOI = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] JPEG_bitstream,
   input  logic        data_ready,
   input  logic        eof_data_partial_ready,
   input  logic [4:0]  end_of_file_bitstream_count,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy,
   output logic        frame_done,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_EMIT, S_STUFF, S_EOI_FF, S_EOI_D9, S_FINISH} state_t;

   logic        r_in_valid;
   logic        r_in_last;
   logic [4:0]  r_in_count;
   logic [31:0] r_in_word;
   logic [37:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic        r_overflow;
   state_t      r_state;
   logic [31:0] r_sr;
   logic [2:0]  r_idx, r_nbytes;
   logic        r_last;

   logic [AW:0] w_level;
   logic        w_empty, w_full, w_wr_en, w_pop;
   logic [37:0] w_head;
   logic        w_head_last;
   logic [4:0]  w_head_count;
   logic [5:0]  w_count_sum;
   logic [2:0]  w_head_nbytes;
   logic [31:0] w_head_sr;
   state_t      w_state_next, w_end_state;
   logic [31:0] w_sr_next;
   logic [2:0]  w_idx_next, w_nbytes_next;
   logic        w_last_next;

   // Input stage: both strobes high means the partial word wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_in_valid <= 1'b0;
         r_in_last  <= 1'b0;
         r_in_count <= '0;
         r_in_word  <= '0;
      end else begin
         r_in_valid <= data_ready | eof_data_partial_ready;
         r_in_last  <= eof_data_partial_ready;
         r_in_count <= eof_data_partial_ready ? end_of_file_bitstream_count : 5'd0;
         r_in_word  <= JPEG_bitstream;
      end
   end

   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_level == '0);
   assign w_full  = (w_level == (AW+1)'(FIFO_DEPTH));
   assign w_wr_en = r_in_valid && !w_full;

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr[AW-1:0]] <= {r_in_last, r_in_count, r_in_word};
   end

   assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
   assign w_head_last   = w_head[37];
   assign w_head_count  = w_head[36:32];
   assign w_count_sum   = {1'b0, w_head_count} + 6'd7;
   assign w_head_nbytes = w_head_last ? w_count_sum[5:3] : 3'd4;
   // Bits below the valid MSBs of the final word are forced to 1.
   assign w_head_sr     = w_head_last ? (w_head[31:0] | (32'hFFFF_FFFF >> w_head_count))
                                      : w_head[31:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
         r_state    <= S_IDLE;
         r_sr       <= '0;
         r_idx      <= '0;
         r_nbytes   <= '0;
         r_last     <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_wr_en};
         r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, w_pop};
         if (r_in_valid && w_full)
            r_overflow <= 1'b1;
         r_state  <= w_state_next;
         r_sr     <= w_sr_next;
         r_idx    <= w_idx_next;
         r_nbytes <= w_nbytes_next;
         r_last   <= w_last_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_sr_next     = r_sr;
      w_idx_next    = r_idx;
      w_nbytes_next = r_nbytes;
      w_last_next   = r_last;
      w_pop         = 1'b0;
      w_end_state   = APPEND_EOI ? S_EOI_FF : S_FINISH;
      byte_out      = 8'h00;
      byte_valid    = 1'b0;
      frame_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop         = 1'b1;
               w_sr_next     = w_head_sr;
               w_nbytes_next = w_head_nbytes;
               w_last_next   = w_head_last;
               w_idx_next    = 3'd0;
               w_state_next  = (w_head_nbytes == 3'd0) ? w_end_state : S_EMIT;
            end
         end
         S_EMIT: begin
            byte_valid = 1'b1;
            byte_out   = r_sr[31:24];
            if (byte_ready) begin
               w_sr_next  = r_sr << 8;
               w_idx_next = r_idx + 3'd1;
               if (r_idx == r_nbytes - 3'd1) begin
                  if (r_last) begin
                     w_state_next = (r_sr[31:24] == 8'hFF) ? S_STUFF : w_end_state;
                  end else if (!w_empty) begin
                     // Back-to-back reload keeps the byte stream bubble-free.
                     w_pop         = 1'b1;
                     w_sr_next     = w_head_sr;
                     w_nbytes_next = w_head_nbytes;
                     w_last_next   = w_head_last;
                     w_idx_next    = 3'd0;
                     w_state_next  = (w_head_nbytes == 3'd0) ? w_end_state : S_EMIT;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end
            end
         end
         S_STUFF: begin
            byte_valid = 1'b1;
            byte_out   = 8'h00;
            if (byte_ready) w_state_next = w_end_state;
         end
         S_EOI_FF: begin
            byte_valid = 1'b1;
            byte_out   = 8'hFF;
            if (byte_ready) w_state_next = S_EOI_D9;
         end
         S_EOI_D9: begin
            byte_valid = 1'b1;
            byte_out   = 8'hD9;
            if (byte_ready) w_state_next = S_FINISH;
         end
         S_FINISH: begin
            frame_done   = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign busy     = r_in_valid || !w_empty || (r_state != S_IDLE);
   assign overflow = r_overflow;
endmodule
